idli_sqi_fetch_m: RTL

//  Instruction fetch front end: drives a quad-SPI (SQI) serial SRAM and streams
//  16b encodings one nibble per GCK to decode, aligned to the 4-cycle sync counter.

---
 rtl/idli_pkg.sv | 14 +
 rtl/idli_sqi_fetch_m.sv | 63 ++++++
 2 files changed

// File: rtl/idli_pkg.sv
// idli_pkg: shared types and constants for the SQI instruction fetch front end.
package idli_pkg;
  typedef enum logic [2:0] {SQI_IDLE, SQI_CMD, SQI_ADDR, SQI_DUMMY, SQI_DATA} sqi_state_t;
  typedef logic [1:0] ctr_t;
  typedef logic [15:0] data_t;
  localparam logic [7:0] SQI_CMD_READ = 8'h03;
  localparam int SQI_CMD_NIBBLES = 2;
  localparam int SQI_ADDR_NIBBLES = 6;
  localparam int SQI_DUMMY_CYCLES = 2;
  localparam int SQI_CNT_W = $clog2(SQI_ADDR_NIBBLES > SQI_DUMMY_CYCLES ? SQI_ADDR_NIBBLES : SQI_DUMMY_CYCLES);
  // First CMD cycle sits at this ctr so the first data nibble lands on ctr==0.
  localparam ctr_t SQI_START_CTR = ctr_t'((4 - (SQI_CMD_NIBBLES + SQI_ADDR_NIBBLES + SQI_DUMMY_CYCLES) % 4) % 4);
  localparam ctr_t SQI_LAUNCH_CTR = SQI_START_CTR - 2'd1;
endpackage

// File: rtl/idli_sqi_fetch_m.sv
// idli_sqi_fetch_m: SQI SRAM instruction fetch, streaming one 16b encoding per sync-counter period.
module idli_sqi_fetch_m
  import idli_pkg::*;
(
  input  logic        i_sqi_gck,
  input  logic        i_sqi_rst,
  input  ctr_t        i_sqi_ctr,
  input  logic        i_sqi_redir,
  input  logic [15:0] i_sqi_redir_pc,
  output logic        o_sqi_cs_n,
  output logic        o_sqi_sck_en,
  output logic [3:0]  o_sqi_sio_o,
  output logic        o_sqi_sio_oe,
  input  logic [3:0]  i_sqi_sio_i,
  output data_t       o_sqi_enc,
  output logic        o_sqi_enc_vld,
  output logic [15:0] o_sqi_pc
);
  sqi_state_t state, state_nx;
  logic [SQI_CNT_W-1:0] cnt;
  logic [31:0] shreg;
  logic [2:0][3:0] buffer;
  logic [15:0] pc;
  logic wrap;
  // The device stream is not wrapped, so stepping past 0xFFFF restarts at 0.
  assign wrap = o_sqi_enc_vld && pc == 16'hFFFF;
  always_ff @(posedge i_sqi_gck)
    if (i_sqi_rst) state <= SQI_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      SQI_IDLE:  state_nx = i_sqi_ctr == SQI_LAUNCH_CTR ? SQI_CMD : SQI_IDLE;
      SQI_CMD:   state_nx = cnt == SQI_CNT_W'(SQI_CMD_NIBBLES - 1) ? SQI_ADDR : SQI_CMD;
      SQI_ADDR:  state_nx = cnt == SQI_CNT_W'(SQI_ADDR_NIBBLES - 1) ? SQI_DUMMY : SQI_ADDR;
      SQI_DUMMY: state_nx = cnt == SQI_CNT_W'(SQI_DUMMY_CYCLES - 1) ? SQI_DATA : SQI_DUMMY;
      SQI_DATA:  state_nx = SQI_DATA;
      default:   state_nx = SQI_IDLE;
    endcase
    if (i_sqi_redir || wrap) state_nx = SQI_IDLE;
  end
  always_ff @(posedge i_sqi_gck)
    if (i_sqi_rst) begin
      cnt <= '0;
      shreg <= '0;
      buffer <= '0;
      pc <= '0;
    end else begin
      cnt <= state_nx != state ? '0 : cnt + 1'b1;
      shreg <= state == SQI_IDLE ? {SQI_CMD_READ, 7'b0, pc, 1'b0} : shreg << 4;
      if (state == SQI_DATA && i_sqi_ctr != 2'd3) buffer[i_sqi_ctr] <= i_sqi_sio_i;
      pc <= i_sqi_redir ? i_sqi_redir_pc : o_sqi_enc_vld ? pc + 16'd1 : pc;
    end
  always_comb begin
    o_sqi_cs_n = state == SQI_IDLE;
    o_sqi_sck_en = state != SQI_IDLE;
    o_sqi_sio_oe = state == SQI_CMD || state == SQI_ADDR;
    o_sqi_sio_o = o_sqi_sio_oe ? shreg[31:28] : 4'h0;
    o_sqi_enc_vld = state == SQI_DATA && i_sqi_ctr == 2'd3 && !i_sqi_redir;
    o_sqi_enc = {i_sqi_sio_i, buffer};
    o_sqi_pc = pc;
  end
endmodule
